// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the CPU/DMA bus arbiter.
// State encoding, counter widths and the MIN_CPU_CYCLES load helper.
package bus_arbiter_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
  localparam int unsigned MIN_CPU_CYCLES_DEF = 2;
  localparam int unsigned STATE_W            = 2;
  localparam int unsigned CD_CNT_W           = 4;
  localparam int unsigned TO_CNT_W           = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_GRANT    = 2'd2,
    ST_COOLDOWN = 2'd3
  } arb_state_e;

  // A zero minimum still guarantees the CPU one cycle between grants.
  function automatic logic [CD_CNT_W-1:0] cooldown_load(input int unsigned min_cycles);
    int unsigned eff;
    eff = (min_cycles == 32'd0) ? 32'd1 : min_cycles;
    return CD_CNT_W'(eff - 32'd1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the DMA/CPU side (master) and the arbiter (slave).
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic               BR;
  logic               cpu_busy;
  logic               dma_end;
  logic               BG;
  logic               cpu_hold;
  logic [STATE_W-1:0] arb_state;
  logic               timeout_err;

  modport master (
    output BR, cpu_busy, dma_end,
    input  BG, cpu_hold, arb_state, timeout_err
  );

  modport slave (
    input  BR, cpu_busy, dma_end,
    output BG, cpu_hold, arb_state, timeout_err
  );

endinterface

// File: rtl/bus_arbiter_cycle_counter.sv
// arb_cycle_counter: loadable saturating down-counter with a zero flag.
module arb_cycle_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/bus_arbiter.sv
// CPU/DMA bus arbiter: drains CPU accesses, grants the bus, then guarantees CPU cycles.
// Optional grant timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MIN_CPU_CYCLES = MIN_CPU_CYCLES_DEF
) (
  input logic          CLK,
  input logic          RESET,
  bus_arbiter_if.slave ifc
);

  localparam logic [CD_CNT_W-1:0] CD_LOAD = cooldown_load(MIN_CPU_CYCLES);

  arb_state_e state_q;
  arb_state_e state_d;
  arb_state_e idle_next_c;
  logic       bg_q;
  logic       bg_d;
  logic       hold_q;
  logic       hold_d;
  logic       cd_load_c;
  logic       cd_dec_c;
  logic       cd_zero_c;
  logic       to_fire_c;
  logic       err_set_c;
  logic       timeout_err_c;

  // Request evaluation shared by IDLE and the end of COOLDOWN.
  always_comb begin
    idle_next_c = ST_IDLE;
    if (ifc.BR) begin
      idle_next_c = ifc.cpu_busy ? ST_DRAIN : ST_GRANT;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_set_c = 1'b0;
    bg_d      = 1'b0;
    hold_d    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = idle_next_c;
      ST_DRAIN: begin
        if (!ifc.BR) begin
          state_d = ST_IDLE;
        end else if (!ifc.cpu_busy) begin
          state_d = ST_GRANT;
        end
      end
      // A normal release takes priority over the timeout.
      ST_GRANT: begin
        if (ifc.dma_end || !ifc.BR) begin
          state_d = ST_COOLDOWN;
        end else if (to_fire_c) begin
          state_d   = ST_COOLDOWN;
          err_set_c = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cd_zero_c) begin
          state_d = idle_next_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bg_d   = (state_d == ST_GRANT);
    hold_d = (state_d == ST_DRAIN) || (state_d == ST_GRANT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      bg_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      hold_q  <= hold_d;
    end
  end

  assign cd_load_c = (state_d == ST_COOLDOWN) && (state_q != ST_COOLDOWN);
  assign cd_dec_c  = (state_q == ST_COOLDOWN);

  arb_cycle_counter #(
    .WIDTH (CD_CNT_W)
  ) u_cooldown_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .load     (cd_load_c),
    .load_val (CD_LOAD),
    .dec      (cd_dec_c),
    .zero_c   (cd_zero_c)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned         TO_EFF  = (TIMEOUT_CYCLES == 32'd0) ? 32'd1 : TIMEOUT_CYCLES;
  localparam logic [TO_CNT_W-1:0] TO_LOAD = TO_CNT_W'(TO_EFF - 32'd1);

  logic to_load_c;
  logic to_dec_c;
  logic to_zero_c;
  logic err_q;
  logic err_d;

  // Counts down the remaining grant cycles; zero in GRANT means the budget is spent.
  assign to_load_c = (state_d == ST_GRANT) && (state_q != ST_GRANT);
  assign to_dec_c  = (state_q == ST_GRANT);

  arb_cycle_counter #(
    .WIDTH (TO_CNT_W)
  ) u_timeout_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .load     (to_load_c),
    .load_val (TO_LOAD),
    .dec      (to_dec_c),
    .zero_c   (to_zero_c)
  );

  assign to_fire_c = to_zero_c;
  assign err_d     = err_q | err_set_c;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign timeout_err_c = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TO_CNT_W'(TIMEOUT_CYCLES), err_set_c};
  assign to_fire_c          = 1'b0;
  assign timeout_err_c      = 1'b0;
`endif

  assign ifc.BG          = bg_q;
  assign ifc.cpu_hold    = hold_q;
  assign ifc.arb_state   = state_q;
  assign ifc.timeout_err = timeout_err_c;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared every cycle against an ownership-based reference model.
module tb_bus_arbiter;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned MIN_CPU = 2;
  localparam int unsigned MIN_EFF = (MIN_CPU == 0) ? 1 : MIN_CPU;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;

  bus_arbiter_if bus ();

  bus_arbiter #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .MIN_CPU_CYCLES (MIN_CPU)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ifc   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the bus, expressed as plain flags and cycle counts.
  bit          m_dma;
  bit          m_wait;
  bit          m_err;
  int unsigned m_guard;
  int unsigned m_glen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_start(input logic br, input logic busy);
    if (br) begin
      if (busy) m_wait = 1'b1;
      else begin
        m_dma  = 1'b1;
        m_glen = 0;
      end
    end
  endtask

  task automatic model_release();
    m_dma   = 1'b0;
    m_guard = MIN_EFF;
  endtask

  task automatic model_step(input logic br, input logic busy, input logic de, input logic rst);
    if (rst) begin
      m_dma = 0; m_wait = 0; m_err = 0; m_guard = 0; m_glen = 0;
    end else if (m_guard > 0) begin
      m_guard--;
      if (m_guard == 0) model_start(br, busy);
    end else if (m_dma) begin
      m_glen++;
      if (de || !br) model_release();
      else if (TO_EN && m_glen >= TIMEOUT) begin
        model_release();
        m_err = 1'b1;
      end
    end else if (m_wait) begin
      if (!br) m_wait = 1'b0;
      else if (!busy) begin
        m_wait = 1'b0;
        m_dma  = 1'b1;
        m_glen = 0;
      end
    end else begin
      model_start(br, busy);
    end
  endtask

  function automatic logic [31:0] exp_state();
    if (m_dma) return 32'd2;
    if (m_wait) return 32'd1;
    if (m_guard > 0) return 32'd3;
    return 32'd0;
  endfunction

  task automatic step(input logic br, input logic busy, input logic de, input logic rst);
    @(negedge CLK);
    bus.BR       = br;
    bus.cpu_busy = busy;
    bus.dma_end  = de;
    RESET        = rst;
    @(posedge CLK);
    model_step(br, busy, de, rst);
    #1;
    check("BG", 32'(bus.BG), 32'(m_dma));
    check("cpu_hold", 32'(bus.cpu_hold), 32'(m_dma | m_wait));
    check("arb_state", 32'(bus.arb_state), exp_state());
    check("timeout_err", 32'(bus.timeout_err), 32'(m_err));
  endtask

  logic br_r;

  initial begin
    bus.BR = 1'b0; bus.cpu_busy = 1'b0; bus.dma_end = 1'b0; RESET = 1'b1;
    m_dma = 0; m_wait = 0; m_err = 0; m_guard = 0; m_glen = 0;

    step(0, 0, 0, 1);
    check("dir_reset_state", 32'(bus.arb_state), 32'd0);

    // Immediate grant from IDLE.
    step(1, 0, 0, 0);
    check("dir_grant_bg", 32'(bus.BG), 32'd1);
    check("dir_grant_state", 32'(bus.arb_state), 32'd2);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Drain while the CPU finishes its access.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check("dir_drain_state", 32'(bus.arb_state), 32'd1);
      check("dir_drain_bg", 32'(bus.BG), 32'd0);
    end
    step(1, 0, 0, 0);
    check("dir_drain_grant", 32'(bus.BG), 32'd1);

    // 12-cycle grant, dma_end, back-to-back request.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("dir_end_bg", 32'(bus.BG), 32'd0);
    check("dir_end_hold", 32'(bus.cpu_hold), 32'd0);
    step(1, 0, 0, 0);
    check("dir_gap1_bg", 32'(bus.BG), 32'd0);
    step(1, 0, 0, 0);
    check("dir_regrant_bg", 32'(bus.BG), 32'd1);

    // Reset in grant cycle 5.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("dir_rst_bg", 32'(bus.BG), 32'd0);
    check("dir_rst_hold", 32'(bus.cpu_hold), 32'd0);
    check("dir_rst_state", 32'(bus.arb_state), 32'd0);

    // Request withdrawn during drain.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("dir_withdraw_state", 32'(bus.arb_state), 32'd0);
    check("dir_withdraw_bg", 32'(bus.BG), 32'd0);

`ifdef BUS_ARBITER_TIMEOUT_EN
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
    check("dir_to_hold_bg", 32'(bus.BG), 32'd1);
    step(1, 0, 0, 0);
    check("dir_to_drop_bg", 32'(bus.BG), 32'd0);
    check("dir_to_err", 32'(bus.timeout_err), 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("dir_to_sticky", 32'(bus.timeout_err), 32'd1);
    step(0, 0, 0, 1);
    check("dir_to_clear", 32'(bus.timeout_err), 32'd0);
`endif

    // Random traffic with level-held requests.
    br_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) br_r = ~br_r;
      step(br_r, $urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(249) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
